// File: rtl/tone_oscillator_pkg.sv
// Shared definitions for the tone oscillator.
//   SILENCE_MAX : dividers below this value mean "no note".
//   wave_sel_e  : waveform select encoding (11 falls back to square).
//   tri_from_saw: folds the 8-bit ramp into a triangle.
package tone_oscillator_pkg;

   localparam int unsigned SILENCE_MAX = 256;

   typedef enum logic [1:0] {
      WaveSquare    = 2'b00,
      WaveSaw       = 2'b01,
      WaveTri       = 2'b10,
      WaveSquareAlt = 2'b11
   } wave_sel_e;

   // Rising half doubles the ramp; once saw[7] sets, the inverse folds it back down.
   function automatic logic [7:0] tri_from_saw(input logic [7:0] saw);
      logic [7:0] dbl;
      dbl = {saw[6:0], 1'b0};
      return saw[7] ? ~dbl : dbl;
   endfunction

endpackage

// File: rtl/tone_oscillator_if.sv
// Control/output bundle of the tone oscillator.
//   en, divider, wave_sel            : driven by the controller (master)
//   sample, note_active, period_tick : driven by the oscillator (slave)
interface tone_oscillator_if;

   logic        en;
   logic [15:0] divider;
   logic [1:0]  wave_sel;
   logic [7:0]  sample;
   logic        note_active;
   logic        period_tick;

   modport master (
      output en, divider, wave_sel,
      input  sample, note_active, period_tick
   );

   modport slave (
      input  en, divider, wave_sel,
      output sample, note_active, period_tick
   );

endinterface

// File: rtl/tone_oscillator_wave_shaper.sv
// Maps the oscillator phase onto an 8-bit waveform value (combinational).
//   wave_sel_i : waveform select
//   cnt_i      : period counter
//   half_i     : half of the active period length (square threshold)
//   saw_i      : ramp value
//   sample_o   : shaped value, registered by the caller
module wave_shaper
   import tone_oscillator_pkg::*;
(
   input  wave_sel_e   wave_sel_i,
   input  logic [15:0] cnt_i,
   input  logic [15:0] half_i,
   input  logic [7:0]  saw_i,
   output logic [7:0]  sample_o
);

   logic [7:0] square;

   assign square = (cnt_i < half_i) ? 8'hFF : 8'h00;

   always_comb begin
      sample_o = square;
      unique case (wave_sel_i)
         WaveSquare:    sample_o = square;
         WaveSaw:       sample_o = saw_i;
         WaveTri:       sample_o = tri_from_saw(saw_i);
         WaveSquareAlt: sample_o = square;
         default:       sample_o = square;
      endcase
   end

endmodule

// File: rtl/tone_oscillator.sv
// Divider-driven tone oscillator with square, sawtooth and triangle outputs.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of tone_oscillator_if
//         en          - low forces idle on the next edge
//         divider     - clocks per period; below SILENCE_MAX means silence
//         wave_sel    - waveform select, applied on the next sample
//         sample      - registered waveform value, one cycle behind the counters
//         note_active - high while an audible divider is in use
//         period_tick - one-cycle pulse after each period wrap
module tone_oscillator
   import tone_oscillator_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   tone_oscillator_if.slave   bus
);

   localparam logic [15:0] SilenceMax = 16'(SILENCE_MAX);

   logic [15:0] act_div_q, act_div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  step_len_q, step_len_d;
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic [7:0]  saw_q, saw_d;
   logic [7:0]  sample_q, sample_d;
   logic        note_active_q, note_active_d;
   logic        period_tick_q, period_tick_d;

   logic        silent;
   logic        div_audible;
   logic        wrap;
   logic        step_done;
   logic [7:0]  shaped;

   assign silent      = act_div_q < SilenceMax;
   assign div_audible = bus.divider >= SilenceMax;
   assign wrap        = cnt_q == (act_div_q - 16'd1);
   assign step_done   = step_cnt_q == (step_len_q - 8'd1);

   wave_shaper u_wave_shaper (
      .wave_sel_i (wave_sel_e'(bus.wave_sel)),
      .cnt_i      (cnt_q),
      .half_i     (act_div_q >> 1),
      .saw_i      (saw_q),
      .sample_o   (shaped)
   );

   always_comb begin
      act_div_d     = act_div_q;
      cnt_d         = cnt_q;
      step_len_d    = step_len_q;
      step_cnt_d    = step_cnt_q;
      saw_d         = saw_q;
      sample_d      = sample_q;
      note_active_d = note_active_q;
      period_tick_d = 1'b0;

      if (!bus.en) begin
         act_div_d     = '0;
         cnt_d         = '0;
         step_cnt_d    = '0;
         saw_d         = '0;
         sample_d      = '0;
         note_active_d = 1'b0;
      end else if (silent) begin
         // Initial load: no tick, counters start from a clean phase.
         act_div_d     = bus.divider;
         step_len_d    = bus.divider[15:8];
         cnt_d         = '0;
         step_cnt_d    = '0;
         saw_d         = '0;
         sample_d      = '0;
         note_active_d = div_audible;
      end else begin
         sample_d = shaped;
         if (wrap) begin
            // Divider changes only take effect here, so a period is never cut short.
            act_div_d     = bus.divider;
            step_len_d    = bus.divider[15:8];
            cnt_d         = '0;
            step_cnt_d    = '0;
            saw_d         = '0;
            note_active_d = div_audible;
            period_tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 16'd1;
            if (step_done) begin
               step_cnt_d = '0;
               if (saw_q != 8'hFF) begin
                  saw_d = saw_q + 8'd1;
               end
            end else begin
               step_cnt_d = step_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_div_q     <= '0;
         cnt_q         <= '0;
         step_len_q    <= '0;
         step_cnt_q    <= '0;
         saw_q         <= '0;
         sample_q      <= '0;
         note_active_q <= 1'b0;
         period_tick_q <= 1'b0;
      end else begin
         act_div_q     <= act_div_d;
         cnt_q         <= cnt_d;
         step_len_q    <= step_len_d;
         step_cnt_q    <= step_cnt_d;
         saw_q         <= saw_d;
         sample_q      <= sample_d;
         note_active_q <= note_active_d;
         period_tick_q <= period_tick_d;
      end
   end

   assign bus.sample      = sample_q;
   assign bus.note_active = note_active_q;
   assign bus.period_tick = period_tick_q;

endmodule

// File: tb/tb_tone_oscillator.sv
module tb_tone_oscillator;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   tone_oscillator_if bus ();

   tone_oscillator u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clears the oscillator, then enables it; returns just after the load edge.
   task automatic start_note(input logic [15:0] div, input logic [1:0] ws);
      bus.en = 1'b0;
      tick();
      bus.divider  = div;
      bus.wave_sel = ws;
      bus.en       = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.divider  = 16'd0;
      bus.wave_sel = 2'b00;
      repeat (2) tick();
      n_tests++;
      if (bus.sample !== 8'h00) begin
         n_fail++; $display("FAIL reset_sample: got %h want 00", bus.sample);
      end
      n_tests++;
      if (bus.note_active !== 1'b0) begin
         n_fail++; $display("FAIL reset_note_active: got %b want 0", bus.note_active);
      end
      n_tests++;
      if (bus.period_tick !== 1'b0) begin
         n_fail++; $display("FAIL reset_period_tick: got %b want 0", bus.period_tick);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.note_active !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got %b want 0", bus.note_active);
      end
   endtask

   task automatic test_square();
      int ff_cnt, zero_cnt, first_zero, tick_cnt, tick_at, na_low;
      logic [7:0] s_end;
      ff_cnt = 0; zero_cnt = 0; first_zero = 0; tick_cnt = 0; tick_at = 0; na_low = 0;
      s_end = 8'h00;
      start_note(16'd38223, 2'b00);
      n_tests++;
      if (bus.note_active !== 1'b1) begin
         n_fail++; $display("FAIL sq_load_note_active: got %b want 1", bus.note_active);
      end
      n_tests++;
      if (bus.period_tick !== 1'b0) begin
         n_fail++; $display("FAIL sq_load_no_tick: got %b want 0", bus.period_tick);
      end
      for (int k = 1; k <= 38224; k++) begin
         tick();
         if (k <= 38223 && bus.sample === 8'hFF) ff_cnt++;
         if (k <= 38223 && bus.sample === 8'h00) zero_cnt++;
         if (bus.sample === 8'h00 && first_zero == 0) first_zero = k;
         if (bus.period_tick === 1'b1) begin
            tick_cnt++;
            if (tick_at == 0) tick_at = k;
         end
         if (bus.note_active !== 1'b1) na_low++;
         if (k == 38224) s_end = bus.sample;
      end
      n_tests++;
      if (ff_cnt != 19111) begin
         n_fail++; $display("FAIL sq_high_cycles: got %0d want 19111", ff_cnt);
      end
      n_tests++;
      if (zero_cnt != 19112) begin
         n_fail++; $display("FAIL sq_low_cycles: got %0d want 19112", zero_cnt);
      end
      n_tests++;
      if (first_zero != 19112) begin
         n_fail++; $display("FAIL sq_first_low: got %0d want 19112", first_zero);
      end
      n_tests++;
      if (tick_cnt != 1 || tick_at != 38223) begin
         n_fail++; $display("FAIL sq_tick: got %0d ticks first at %0d want 1 at 38223",
                            tick_cnt, tick_at);
      end
      n_tests++;
      if (na_low != 0) begin
         n_fail++; $display("FAIL sq_note_active_drop: got %0d low cycles want 0", na_low);
      end
      n_tests++;
      if (s_end !== 8'hFF) begin
         n_fail++; $display("FAIL sq_next_period_high: got %h want ff", s_end);
      end
   endtask

   task automatic test_silence();
      int nz, na_hi, ticks, tick_at;
      logic [7:0] s128, s129;
      nz = 0; na_hi = 0; ticks = 0; tick_at = 0; s128 = 8'h00; s129 = 8'hFF;
      start_note(16'd1, 2'b00);
      for (int k = 1; k <= 2000; k++) begin
         tick();
         if (bus.sample !== 8'h00) nz++;
         if (bus.note_active !== 1'b0) na_hi++;
         if (bus.period_tick !== 1'b0) ticks++;
      end
      n_tests++;
      if (nz != 0) begin
         n_fail++; $display("FAIL silent_sample: got %0d nonzero want 0", nz);
      end
      n_tests++;
      if (na_hi != 0) begin
         n_fail++; $display("FAIL silent_note_active: got %0d high want 0", na_hi);
      end
      n_tests++;
      if (ticks != 0) begin
         n_fail++; $display("FAIL silent_tick: got %0d ticks want 0", ticks);
      end
      na_hi = 0; ticks = 0;
      start_note(16'd255, 2'b00);
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (bus.note_active !== 1'b0) na_hi++;
         if (bus.period_tick !== 1'b0) ticks++;
      end
      n_tests++;
      if (na_hi != 0 || ticks != 0) begin
         n_fail++; $display("FAIL div255_silent: got %0d active %0d ticks want 0 0",
                            na_hi, ticks);
      end
      start_note(16'd256, 2'b00);
      n_tests++;
      if (bus.note_active !== 1'b1) begin
         n_fail++; $display("FAIL div256_active: got %b want 1", bus.note_active);
      end
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (k == 128) s128 = bus.sample;
         if (k == 129) s129 = bus.sample;
         if (bus.period_tick === 1'b1 && tick_at == 0) tick_at = k;
      end
      n_tests++;
      if (s128 !== 8'hFF || s129 !== 8'h00) begin
         n_fail++; $display("FAIL div256_square_edge: got %h/%h want ff/00", s128, s129);
      end
      n_tests++;
      if (tick_at != 256) begin
         n_fail++; $display("FAIL div256_tick: got %0d want 256", tick_at);
      end
   endtask

   task automatic test_divider_change();
      int ticks[8];
      int nt, na_fall;
      nt = 0; na_fall = 0;
      for (int i = 0; i < 8; i++) ticks[i] = 0;
      start_note(16'd1000, 2'b00);
      for (int k = 1; k <= 2900; k++) begin
         tick();
         if (k == 100) bus.divider = 16'd600;
         if (k == 2300) bus.divider = 16'd1;
         if (bus.period_tick === 1'b1) begin
            if (nt < 8) ticks[nt] = k;
            nt++;
         end
         if (bus.note_active === 1'b0 && na_fall == 0) na_fall = k;
      end
      n_tests++;
      if (nt != 4) begin
         n_fail++; $display("FAIL chg_tick_count: got %0d want 4", nt);
      end
      n_tests++;
      if (ticks[0] != 1000) begin
         n_fail++; $display("FAIL chg_first_tick: got %0d want 1000", ticks[0]);
      end
      n_tests++;
      if (ticks[1] != 1600 || ticks[2] != 2200) begin
         n_fail++; $display("FAIL chg_new_period: got %0d,%0d want 1600,2200",
                            ticks[1], ticks[2]);
      end
      n_tests++;
      if (ticks[3] != 2800 || na_fall != 2800) begin
         n_fail++; $display("FAIL chg_to_silence: got tick %0d fall %0d want 2800 2800",
                            ticks[3], na_fall);
      end
      n_tests++;
      if (bus.sample !== 8'h00) begin
         n_fail++; $display("FAIL chg_silent_sample: got %h want 00", bus.sample);
      end
   endtask

   task automatic test_sawtooth();
      int bad, e;
      logic [7:0] s100, s101, s25501, s25600, s25601, sq, s5002;
      bad = 0;
      s100 = 8'hAA; s101 = 8'hAA; s25501 = 8'hAA; s25600 = 8'hAA; s25601 = 8'hAA;
      sq = 8'hAA; s5002 = 8'hAA;
      start_note(16'd25600, 2'b01);
      for (int k = 1; k <= 25601; k++) begin
         tick();
         e = (k == 25601) ? 0 : (((k - 1) / 100 > 255) ? 255 : (k - 1) / 100);
         if (k == 5001) begin
            sq = bus.sample;
            bus.wave_sel = 2'b01;
         end else if (bus.sample !== 8'(e)) begin
            bad++;
         end
         if (k == 5000) bus.wave_sel = 2'b00;
         if (k == 5002) s5002 = bus.sample;
         if (k == 100) s100 = bus.sample;
         if (k == 101) s101 = bus.sample;
         if (k == 25501) s25501 = bus.sample;
         if (k == 25600) s25600 = bus.sample;
         if (k == 25601) s25601 = bus.sample;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL saw_ramp: got %0d wrong samples want 0", bad);
      end
      n_tests++;
      if (s100 !== 8'd0 || s101 !== 8'd1) begin
         n_fail++; $display("FAIL saw_first_step: got %0d/%0d want 0/1", s100, s101);
      end
      n_tests++;
      if (s25501 !== 8'd255 || s25600 !== 8'd255) begin
         n_fail++; $display("FAIL saw_saturate: got %0d/%0d want 255/255", s25501, s25600);
      end
      n_tests++;
      if (s25601 !== 8'd0) begin
         n_fail++; $display("FAIL saw_wrap: got %0d want 0", s25601);
      end
      n_tests++;
      if (sq !== 8'hFF || s5002 !== 8'd50) begin
         n_fail++; $display("FAIL wave_switch: got %h then %0d want ff then 50", sq, s5002);
      end
   endtask

   task automatic test_triangle();
      int bad, s;
      logic [7:0] sv, dbl, e;
      logic [7:0] p11, p1271, p1281, p1291, p2551, p2561;
      bad = 0;
      p11 = 8'hAA; p1271 = 8'hAA; p1281 = 8'hAA; p1291 = 8'hAA; p2551 = 8'hAA; p2561 = 8'hAA;
      start_note(16'd2560, 2'b10);
      for (int k = 1; k <= 2561; k++) begin
         tick();
         s   = (k == 2561) ? 0 : (((k - 1) / 10 > 255) ? 255 : (k - 1) / 10);
         sv  = 8'(s);
         dbl = {sv[6:0], 1'b0};
         e   = sv[7] ? ~dbl : dbl;
         if (bus.sample !== e) bad++;
         if (k == 11) p11 = bus.sample;
         if (k == 1271) p1271 = bus.sample;
         if (k == 1281) p1281 = bus.sample;
         if (k == 1291) p1291 = bus.sample;
         if (k == 2551) p2551 = bus.sample;
         if (k == 2561) p2561 = bus.sample;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL tri_shape: got %0d wrong samples want 0", bad);
      end
      n_tests++;
      if (p11 !== 8'd2 || p1271 !== 8'd254) begin
         n_fail++; $display("FAIL tri_rise: got %0d/%0d want 2/254", p11, p1271);
      end
      n_tests++;
      if (p1281 !== 8'd255 || p1291 !== 8'd253) begin
         n_fail++; $display("FAIL tri_peak: got %0d/%0d want 255/253", p1281, p1291);
      end
      n_tests++;
      if (p2551 !== 8'd1 || p2561 !== 8'd0) begin
         n_fail++; $display("FAIL tri_end: got %0d/%0d want 1/0", p2551, p2561);
      end
   endtask

   task automatic test_en_rst();
      int tick_at;
      logic [7:0] s1;
      tick_at = 0; s1 = 8'h00;
      start_note(16'd1000, 2'b00);
      repeat (300) tick();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (bus.sample !== 8'h00 || bus.note_active !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got %h/%b want 00/0", bus.sample, bus.note_active);
      end
      tick();
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.note_active !== 1'b1) begin
         n_fail++; $display("FAIL rst_resume: got %b want 1", bus.note_active);
      end
      repeat (300) tick();
      n_tests++;
      if (bus.sample !== 8'hFF) begin
         n_fail++; $display("FAIL rst_running: got %h want ff", bus.sample);
      end
      bus.en = 1'b0;
      tick();
      n_tests++;
      if (bus.sample !== 8'h00 || bus.note_active !== 1'b0 || bus.period_tick !== 1'b0) begin
         n_fail++; $display("FAIL en_low: got %h/%b/%b want 00/0/0",
                            bus.sample, bus.note_active, bus.period_tick);
      end
      bus.en = 1'b1;
      tick();
      n_tests++;
      if (bus.note_active !== 1'b1) begin
         n_fail++; $display("FAIL reenable_load: got %b want 1", bus.note_active);
      end
      for (int k = 1; k <= 1000; k++) begin
         tick();
         if (k == 1) s1 = bus.sample;
         if (bus.period_tick === 1'b1 && tick_at == 0) tick_at = k;
      end
      n_tests++;
      if (s1 !== 8'hFF || tick_at != 1000) begin
         n_fail++; $display("FAIL reenable_fresh: got %h tick %0d want ff tick 1000", s1, tick_at);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_square();
      test_silence();
      test_divider_change();
      test_sawtooth();
      test_triangle();
      test_en_rst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_oscillator.md
TONE_OSCILLATOR -- requirements
Module: tone_oscillator

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port en  input  1  oscillator enable; low forces idle.
REQ-004 SHALL have port divider  input  16  clk cycles per output period; values below 256 mean silence (keypad default code 1).
REQ-005 SHALL have port wave_sel  input  2  waveform: 00 square, 01 sawtooth, 10 triangle, 11 treated as square.
REQ-006 SHALL have port sample  output  8  unsigned registered waveform sample.
REQ-007 SHALL have port note_active  output  1  high while a non-silent divider is in use.
REQ-008 SHALL have port period_tick  output  1  one-cycle pulse at each period boundary.

Function
REQ-009 SHALL hold internal registers act_div (16), cnt (16), step_len (8), step_cnt (8), saw (8).
REQ-010 SHALL treat act_div < 256 as the silent state: cnt, step_cnt and saw held at 0; sample 0; note_active 0; period_tick 0.
REQ-011 SHALL, when silent and en=1, load act_div<=divider, step_len<=divider[15:8], cnt<=0, saw<=0 on the next edge; note_active rises that edge if divider >= 256.
REQ-012 SHALL, when running, increment cnt each cycle from 0 to act_div-1, then wrap to 0.
REQ-013 SHALL, on the wrap edge, load act_div, step_len from the current divider input (so divider changes, including to silence, take effect only at period boundaries) and clear step_cnt and saw.
REQ-014 SHALL set period_tick high for exactly the one cycle following each wrap edge; never on the initial load.
REQ-015 SHALL advance step_cnt each running cycle; when step_cnt = step_len-1, clear step_cnt and increment saw, saturating at 255 until wrap.
REQ-016 SHALL compute square as 8'hFF when cnt < act_div>>1, else 8'h00.
REQ-017 SHALL compute triangle as {saw[6:0],0} when saw[7]=0, else bitwise inverse of {saw[6:0],0}.
REQ-018 SHALL register sample from current-cycle cnt/saw, so sample lags the counters by one cycle.
REQ-019 SHALL, when en=0, on the next edge force act_div, cnt, step_cnt, saw, sample, note_active, period_tick to 0 regardless of phase.
REQ-020 SHALL apply wave_sel changes immediately (next sample) without disturbing counters.
REQ-021 SHALL use purely unsigned arithmetic; no counter exceeds its declared width.

Reset
REQ-022 SHALL, while rst=1, asynchronously drive all registers and outputs to 0.
REQ-023 SHALL, after rst deasserts, resume per REQ-011 on the first edge with en=1.

Structure
REQ-024 SHALL take the wave_sel enum typedef and the SILENCE_MAX=256 constant from the shared synth package.
REQ-025 SHALL place waveform selection (square/saw/triangle mapping to sample) in one sub-module, wave_shaper; counters remain in tone_oscillator.

Verification
REQ-026 SHALL cover: rst, en=1, divider=38223, wave_sel=00 -> note_active high; sample FF for 19111 cycles, 00 for 19112; period_tick every 38223 cycles.
REQ-027 SHALL cover: en=1, divider=1 -> note_active 0, sample 0, no period_tick over 100000 cycles.
REQ-028 SHALL cover: divider 38223 changed to 19111 at cnt=1000 -> first tick still after 38223 cycles, subsequent ticks every 19111.
REQ-029 SHALL cover: divider=25600, wave_sel=01 -> sample steps by 1 every 100 cycles, reaches 255, holds until wrap at 25600, then returns to 0.
REQ-030 SHALL cover: divider=25600, wave_sel=10 -> sample rises 0..254 in steps of 2, jumps to 255 at saw=128, falls to 1 at saw=255.
REQ-031 SHALL cover: rst pulsed mid-period with en=1 -> all outputs 0 immediately; en low mid-period -> outputs 0 next edge; re-enable -> fresh period from cnt=0.
